// File: rtl/asg_seg_seq.sv
// asg_seg_seq -- segment sequencer for an arbitrary signal generator channel.
//
// Holds a table of 2**NSEG_BITS segments. Each segment has a buffer offset,
// a size, a step and a control word. The sequencer walks the table and drives
// one channel: it loads the configuration, resets and triggers the channel,
// and counts table-wrap pulses until the segment is finished. A segment then
// either chains to its successor or ends the sequence.
//
// Ports
//   dac_clk_i    DAC clock
//   dac_rst_i    asynchronous active-high reset
//   cfg_we_i     segment table write strobe
//   cfg_seg_i    segment index to write
//   cfg_field_i  field select: 0=ofs 1=size 2=step 3=ctrl
//   cfg_wdata_i  write data; ctrl = {last[24], next[16+:NSEG_BITS], ncyc[15:0]}
//   start_i      start pulse (honoured only when idle)
//   start_seg_i  first segment of the sequence
//   abort_i      stop immediately; has priority over everything else
//   wrap_i       channel table-wrap pulse
//   ch_ofs_o     channel buffer offset
//   ch_size_o    channel buffer size
//   ch_step_o    channel phase step
//   ch_rst_o     channel FSM reset
//   ch_trig_o    channel start pulse
//   busy_o       sequence active
//   seg_o        current segment index
//   seg_cnt_o    segments started since start (saturates)
//   done_o       one-cycle end-of-sequence pulse
module asg_seg_seq #(
    parameter int RSZ       = 14,
    parameter int NSEG_BITS = 3
) (
    input  logic                 dac_clk_i,
    input  logic                 dac_rst_i,
    input  logic                 cfg_we_i,
    input  logic [NSEG_BITS-1:0] cfg_seg_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [31:0]          cfg_wdata_i,
    input  logic                 start_i,
    input  logic [NSEG_BITS-1:0] start_seg_i,
    input  logic                 abort_i,
    input  logic                 wrap_i,
    output logic [RSZ+15:0]      ch_ofs_o,
    output logic [RSZ+15:0]      ch_size_o,
    output logic [RSZ+15:0]      ch_step_o,
    output logic                 ch_rst_o,
    output logic                 ch_trig_o,
    output logic                 busy_o,
    output logic [NSEG_BITS-1:0] seg_o,
    output logic [15:0]          seg_cnt_o,
    output logic                 done_o
);

    localparam int W    = RSZ + 16;
    localparam int NSEG = 2 ** NSEG_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRIME,
        S_RUN,
        S_DONE
    } state_t;

    // Segment table
    logic [W-1:0]         ofs_tbl_q  [NSEG];
    logic [W-1:0]         size_tbl_q [NSEG];
    logic [W-1:0]         step_tbl_q [NSEG];
    logic [15:0]          ncyc_tbl_q [NSEG];
    logic [NSEG_BITS-1:0] next_tbl_q [NSEG];
    logic                 last_tbl_q [NSEG];

    // Sequencer state
    state_t               state_q, state_d;
    logic [NSEG_BITS-1:0] seg_q, seg_d;
    logic [15:0]          seg_cnt_q, seg_cnt_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [NSEG_BITS-1:0] next_q, next_d;
    logic                 last_q, last_d;
    logic [W-1:0]         ofs_q, ofs_d;
    logic [W-1:0]         size_q, size_d;
    logic [W-1:0]         step_q, step_d;

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            for (int i = 0; i < NSEG; i++) begin
                ofs_tbl_q[i]  <= '0;
                size_tbl_q[i] <= '0;
                step_tbl_q[i] <= '0;
                ncyc_tbl_q[i] <= '0;
                next_tbl_q[i] <= '0;
                last_tbl_q[i] <= 1'b0;
            end
        end else if (cfg_we_i) begin
            case (cfg_field_i)
                2'd0: ofs_tbl_q[cfg_seg_i]  <= W'(cfg_wdata_i);
                2'd1: size_tbl_q[cfg_seg_i] <= W'(cfg_wdata_i);
                2'd2: step_tbl_q[cfg_seg_i] <= W'(cfg_wdata_i);
                2'd3: begin
                    ncyc_tbl_q[cfg_seg_i] <= cfg_wdata_i[15:0];
                    next_tbl_q[cfg_seg_i] <= cfg_wdata_i[16 +: NSEG_BITS];
                    last_tbl_q[cfg_seg_i] <= cfg_wdata_i[24];
                end
            endcase
        end
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state_q   <= S_IDLE;
            seg_q     <= '0;
            seg_cnt_q <= '0;
            cnt_q     <= '0;
            next_q    <= '0;
            last_q    <= 1'b0;
            ofs_q     <= '0;
            size_q    <= '0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            seg_q     <= seg_d;
            seg_cnt_q <= seg_cnt_d;
            cnt_q     <= cnt_d;
            next_q    <= next_d;
            last_q    <= last_d;
            ofs_q     <= ofs_d;
            size_q    <= size_d;
            step_q    <= step_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        seg_d     = seg_q;
        seg_cnt_d = seg_cnt_q;
        cnt_d     = cnt_q;
        next_d    = next_q;
        last_d    = last_q;
        ofs_d     = ofs_q;
        size_d    = size_q;
        step_d    = step_q;

        if (abort_i) begin
            // Abort wins in every state; channel configuration is left as is.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        seg_d     = start_seg_i;
                        seg_cnt_d = '0;
                        state_d   = S_LOAD;
                    end
                end
                S_LOAD: begin
                    // next/last are captured here too, so table edits to the
                    // running segment only matter at its next load.
                    ofs_d   = ofs_tbl_q[seg_q];
                    size_d  = size_tbl_q[seg_q];
                    step_d  = step_tbl_q[seg_q];
                    cnt_d   = ncyc_tbl_q[seg_q];
                    next_d  = next_tbl_q[seg_q];
                    last_d  = last_tbl_q[seg_q];
                    if (seg_cnt_q != 16'hFFFF) begin
                        seg_cnt_d = seg_cnt_q + 16'd1;
                    end
                    state_d = S_PRIME;
                end
                S_PRIME: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    // A zero count means run forever: wraps never reach 1.
                    if (wrap_i && (cnt_q != 16'd0)) begin
                        cnt_d = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            if (last_q) begin
                                state_d = S_DONE;
                            end else begin
                                seg_d   = next_q;
                                state_d = S_LOAD;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign ch_rst_o  = !((state_q == S_PRIME) || (state_q == S_RUN));
    assign ch_trig_o = (state_q == S_PRIME);
    assign done_o    = (state_q == S_DONE);
    assign seg_o     = seg_q;
    assign seg_cnt_o = seg_cnt_q;
    assign ch_ofs_o  = ofs_q;
    assign ch_size_o = size_q;
    assign ch_step_o = step_q;

endmodule

// File: doc/asg_seg_seq.md
ASG_SEG_SEQ -- requirements
Module: asg_seg_seq

Interface
REQ-001 SHALL have parameter RSZ, default 14, buffer address width; table fields ofs/size/step are RSZ+16 bits wide.
REQ-002 SHALL have parameter NSEG_BITS, default 3, segment index width (2**NSEG_BITS table entries).
REQ-003 SHALL have one clock and an asynchronous active-high reset: dac_clk_i in 1 DAC clock; dac_rst_i in 1 reset, asynchronous, active-high.
REQ-004 cfg_we_i in 1: segment table write strobe.
REQ-005 cfg_seg_i in NSEG_BITS: segment index to write.
REQ-006 cfg_field_i in 2: field select, 0=ofs, 1=size, 2=step, 3=ctrl.
REQ-007 cfg_wdata_i in 32: write data; ctrl word = ncyc[15:0], next[16+NSEG_BITS-1:16], last[24].
REQ-008 start_i in 1: start pulse; start_seg_i in NSEG_BITS: first segment index.
REQ-009 abort_i in 1: stop sequence immediately.
REQ-010 wrap_i in 1: channel table-wrap pulse (one per completed table cycle).
REQ-011 ch_ofs_o, ch_size_o, ch_step_o out RSZ+16: channel configuration.
REQ-012 ch_rst_o out 1: channel FSM reset; ch_trig_o out 1: channel start pulse.
REQ-013 busy_o out 1; seg_o out NSEG_BITS: current segment; seg_cnt_o out 16: segments started since start; done_o out 1: end pulse.

Function
REQ-014 Table SHALL be 2**NSEG_BITS entries x 4 fields, written on cfg_we_i in the same cycle, at any time, including while busy.
REQ-015 Channel outputs SHALL be registered copies loaded only in LOAD; a write to the running segment SHALL take effect only at its next LOAD.
REQ-016 FSM states SHALL be IDLE, LOAD, PRIME, RUN, DONE.
REQ-017 IDLE: ch_rst_o=1, busy_o=0; on start_i: seg_o<=start_seg_i, seg_cnt_o<=0, go LOAD next cycle.
REQ-018 LOAD (1 cycle): ch_ofs/size/step_o<=table[seg_o]; cycle counter<=ncyc; seg_cnt_o+=1 (saturate at 0xFFFF); ch_rst_o=1; go PRIME.
REQ-019 PRIME (1 cycle): ch_rst_o=0, ch_trig_o=1; go RUN.
REQ-020 RUN: ch_rst_o=0; each wrap_i decrements counter; on wrap_i with counter==1: if last=1 go DONE, else seg_o<=next, go LOAD.
REQ-021 ncyc=0 SHALL mean infinite: wrap_i ignored, segment runs until abort_i.
REQ-022 wrap_i outside RUN SHALL be ignored.
REQ-023 DONE (1 cycle): done_o=1, ch_rst_o=1; go IDLE.
REQ-024 busy_o SHALL be 1 in LOAD, PRIME, RUN, DONE.
REQ-025 start_i when not IDLE SHALL be ignored.
REQ-026 abort_i SHALL have priority over start_i and wrap_i in every state: go IDLE next cycle, ch_rst_o=1, no done_o pulse; channel config outputs hold last value.
REQ-027 next==seg_o SHALL be legal (self-loop, reloads and retriggers).
REQ-028 Latency: start_i at cycle N -> ch_trig_o at N+2; final wrap_i at N -> next segment ch_trig_o at N+2, or done_o at N+1.

Reset
REQ-029 On dac_rst_i: state IDLE, ch_rst_o=1, ch_trig_o=0, busy_o=0, done_o=0, seg_o=0, seg_cnt_o=0, ch_ofs/size/step_o=0, counter=0, all table entries 0.
REQ-030 Reset asserted mid-RUN SHALL take effect asynchronously; after release, block SHALL wait in IDLE for start_i.

Verification
REQ-031 Seg0 {ofs=0, size=0x3FFF_FFFF, step=0x1_0000, ncyc=2, last=1}; start_i, seg 0 -> ch_trig_o 2 cycles later; two wrap_i -> done_o one cycle after second wrap, busy_o=0, seg_cnt_o=1.
REQ-032 Seg0 ncyc=1 next=3, seg3 ncyc=3 last=1 -> seg_o sequence 0,3; seg3 ch_ofs_o loaded; done_o after 4 total wraps; seg_cnt_o=2.
REQ-033 Seg1 ncyc=0; start at seg 1, 10 wrap_i -> remains RUN; abort_i -> IDLE next cycle, ch_rst_o=1, no done_o.
REQ-034 During RUN of seg0 (ncyc=2) write seg0 ofs=0x100 -> ch_ofs_o unchanged until self-loop (next=0, last=0) reload, then 0x100.
REQ-035 start_i and abort_i same cycle in IDLE -> stays IDLE; start_i during RUN -> ignored, seg_o unchanged.
REQ-036 dac_rst_i pulse mid-RUN -> all outputs to REQ-029 values immediately; table reads back zero via ch_*_o after next start.
